// File: rtl/gelato_warp_dispatch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gelato_warp_dispatch: round-robin dispatch of per-warp queue heads into one
// registered output stage. Optional: GELATO_DISPATCH_STATS_EN (accept counter).
// Rev 1.0
// ----------------------------------------------------------------------------
module gelato_warp_dispatch #(
  parameter int NUM_WARPS = 4,
  parameter int DATA_W    = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_WARPS-1:0]          in_valid,
  input  logic [NUM_WARPS*DATA_W-1:0]   in_data,
  output logic [NUM_WARPS-1:0]          in_ready,
  input  logic [NUM_WARPS-1:0]          warp_stall,
  input  logic                          flush,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out_data,
  output logic [$clog2(NUM_WARPS)-1:0]  out_warp_id,
  input  logic                          out_ready,
  output logic [31:0]                   dispatch_count
);

  localparam int WID_W = $clog2(NUM_WARPS);

  logic [WID_W-1:0]     rr_ptr;
  logic [NUM_WARPS-1:0] eligible;
  logic [NUM_WARPS-1:0] grant;
  logic                 found;
  logic [WID_W-1:0]     scan_idx;
  logic [WID_W-1:0]     sel_idx;
  logic [DATA_W-1:0]    sel_data;
  logic                 load_en;
  logic                 take;

  assign eligible = in_valid & ~warp_stall;
  assign load_en  = !flush && (!out_valid || out_ready);
  assign take     = load_en && found;

  // NUM_WARPS is a power of two, so WID_W-bit addition wraps modulo NUM_WARPS.
  always_comb begin
    found    = 1'b0;
    scan_idx = '0;
    sel_idx  = '0;
    sel_data = '0;
    grant    = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      scan_idx = rr_ptr + WID_W'(i);
      if (!found && eligible[scan_idx]) begin
        found   = 1'b1;
        sel_idx = scan_idx;
      end
    end
    for (int k = 0; k < NUM_WARPS; k++) begin
      if (found && (sel_idx == WID_W'(k))) begin
        grant[k] = 1'b1;
        sel_data = in_data[k*DATA_W +: DATA_W];
      end
    end
  end

  assign in_ready = {NUM_WARPS{rst_n && load_en}} & grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_warp_id <= '0;
      rr_ptr      <= '0;
    end else if (take) begin
      out_valid   <= 1'b1;
      out_data    <= sel_data;
      out_warp_id <= sel_idx;
      rr_ptr      <= sel_idx + WID_W'(1);
    end else if (flush || out_ready) begin
      out_valid   <= 1'b0;
    end
  end

`ifdef GELATO_DISPATCH_STATS_EN
  logic [31:0] accept_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accept_count <= '0;
    end else if (out_valid && out_ready && !flush) begin
      accept_count <= accept_count + 32'd1;
    end
  end

  assign dispatch_count = accept_count;
`else
  assign dispatch_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gelato_warp_dispatch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_gelato_warp_dispatch: directed vectors for gelato_warp_dispatch.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_gelato_warp_dispatch;

  localparam int NUM_WARPS = 4;
  localparam int DATA_W    = 32;
  localparam int WID_W     = 2;

  logic                        clk;
  logic                        rst_n;
  logic [NUM_WARPS-1:0]        in_valid;
  logic [NUM_WARPS*DATA_W-1:0] in_data;
  logic [NUM_WARPS-1:0]        in_ready;
  logic [NUM_WARPS-1:0]        warp_stall;
  logic                        flush;
  logic                        out_valid;
  logic [DATA_W-1:0]           out_data;
  logic [WID_W-1:0]            out_warp_id;
  logic                        out_ready;
  logic [31:0]                 dispatch_count;

  int n_checks = 0;
  int n_pass   = 0;

  gelato_warp_dispatch #(
    .NUM_WARPS (NUM_WARPS),
    .DATA_W    (DATA_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .warp_stall     (warp_stall),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_warp_id    (out_warp_id),
    .out_ready      (out_ready),
    .dispatch_count (dispatch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic default_data();
    for (int k = 0; k < NUM_WARPS; k++) in_data[k*DATA_W +: DATA_W] = 32'hA000_0000 | k;
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 4'b1111;
    warp_stall = '0;
    flush      = 1'b0;
    out_ready  = 1'b0;
    default_data();

    // Reset state; in_ready must stay low even with every warp eligible.
    step();
    step();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_warp_id", {30'd0, out_warp_id}, 32'd0);
    check("rst_dispatch_count", dispatch_count, 32'd0);
    check("rst_in_ready", {28'd0, in_ready}, 32'd0);

    // Full round robin at one word per cycle.
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("rr_in_ready_first", {28'd0, in_ready}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("rr_valid_%0d", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("rr_warp_%0d", i), {30'd0, out_warp_id}, i % 4);
      check($sformatf("rr_data_%0d", i), out_data, 32'hA000_0000 | (i % 4));
    end

    // Mid-operation reset discards the held word and returns rr_ptr to 0.
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_data", out_data, 32'd0);
    check("midrst_in_ready", {28'd0, in_ready}, 32'd0);
    step();
    rst_n    = 1'b1;
    in_valid = 4'b1010;
    step();
    check("sparse_warp_a", {30'd0, out_warp_id}, 32'd1);
    check("sparse_data_a", out_data, 32'hA000_0001);
    step();
    check("sparse_warp_b", {30'd0, out_warp_id}, 32'd3);
    step();
    check("sparse_warp_c", {30'd0, out_warp_id}, 32'd1);
    check("sparse_valid_c", {31'd0, out_valid}, 32'd1);

    // Backpressure: rr_ptr is 2, load 0xDEADBEEF from warp 2 and hold it.
    in_valid                  = 4'b0100;
    in_data[2*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
    step();
    check("bp_load_data", out_data, 32'hDEAD_BEEF);
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    default_data();
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp_in_ready_%0d", i), {28'd0, in_ready}, 32'd0);
      step();
      check($sformatf("bp_hold_data_%0d", i), out_data, 32'hDEAD_BEEF);
      check($sformatf("bp_hold_warp_%0d", i), {30'd0, out_warp_id}, 32'd2);
      check($sformatf("bp_hold_valid_%0d", i), {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", {28'd0, in_ready}, 32'h8);
    step();
    check("bp_next_warp", {30'd0, out_warp_id}, 32'd3);
    check("bp_next_data", out_data, 32'hA000_0003);

    // Stalled warp is never granted; output drains; release grants it.
    in_valid   = 4'b0100;
    warp_stall = 4'b0100;
    #1;
    check("stall_in_ready", {28'd0, in_ready}, 32'd0);
    step();
    check("stall_drain_valid", {31'd0, out_valid}, 32'd0);
    step();
    check("stall_idle_valid", {31'd0, out_valid}, 32'd0);
    warp_stall = 4'b0000;
    #1;
    check("unstall_in_ready", {28'd0, in_ready}, 32'h4);
    step();
    check("unstall_warp", {30'd0, out_warp_id}, 32'd2);
    check("unstall_valid", {31'd0, out_valid}, 32'd1);

    // A stall raised after registration does not disturb the held word.
    out_ready  = 1'b0;
    warp_stall = 4'b1111;
    step();
    check("late_stall_valid", {31'd0, out_valid}, 32'd1);
    check("late_stall_warp", {30'd0, out_warp_id}, 32'd2);
    warp_stall = 4'b0000;

    // Flush overrides out_ready, grants nothing, and keeps rr_ptr at 3.
    out_ready = 1'b1;
    in_valid  = 4'b1111;
    flush     = 1'b1;
    #1;
    check("flush_in_ready", {28'd0, in_ready}, 32'd0);
    step();
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    flush = 1'b0;
    #1;
    check("postflush_in_ready", {28'd0, in_ready}, 32'h8);
    step();
    check("postflush_warp", {30'd0, out_warp_id}, 32'd3);

    // Accept counter: the first edge loads, the next ten each accept a word.
    rst_n = 1'b0;
    step();
    check("cnt_after_rst", dispatch_count, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) step();
    out_ready = 1'b0;
    in_valid  = 4'b0000;
`ifdef GELATO_DISPATCH_STATS_EN
    check("cnt_ten", dispatch_count, 32'd10);
    step();
    check("cnt_hold", dispatch_count, 32'd10);
`else
    check("cnt_ten", dispatch_count, 32'd0);
    step();
    check("cnt_hold", dispatch_count, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gelato_warp_dispatch.md
GELATO_WARP_DISPATCH -- requirements
Module: gelato_warp_dispatch

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4: number of per-warp instruction queues; power of two, 2..16.
REQ-002 SHALL have parameter DATA_W, default 32: instruction word width.
REQ-003 SHALL derive localparam WID_W = $clog2(NUM_WARPS).
REQ-004 SHALL have port clk  input  1  clock, all state rising-edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  NUM_WARPS  per-warp queue head valid.
REQ-007 SHALL have port in_data  input  NUM_WARPS*DATA_W  per-warp head word; warp k at bits [k*DATA_W +: DATA_W].
REQ-008 SHALL have port in_ready  output  NUM_WARPS  per-warp pop strobe.
REQ-009 SHALL have port warp_stall  input  NUM_WARPS  scoreboard hold; 1 = warp ineligible.
REQ-010 SHALL have port flush  input  1  synchronous discard of the output stage.
REQ-011 SHALL have port out_valid  output  1  dispatched word valid.
REQ-012 SHALL have port out_data  output  DATA_W  dispatched word.
REQ-013 SHALL have port out_warp_id  output  WID_W  source warp of out_data.
REQ-014 SHALL have port out_ready  input  1  downstream accept.
REQ-015 SHALL have port dispatch_count  output  32  total words accepted downstream.

Function
REQ-016 SHALL treat warp k as eligible iff in_valid[k] && !warp_stall[k].
REQ-017 SHALL compute load_en = !flush && (!out_valid || out_ready).
REQ-018 SHALL grant the first eligible warp scanning rr_ptr, rr_ptr+1, ... modulo NUM_WARPS; at most one grant per cycle.
REQ-019 SHALL drive in_ready[k] = load_en && grant[k], combinationally; all other bits 0.
REQ-020 SHALL, on a grant to warp k, register in_data[k] and k into out_data/out_warp_id, set out_valid=1 next cycle, and set rr_ptr = (k+1) mod NUM_WARPS, wrapping from NUM_WARPS-1 to 0.
REQ-021 SHALL leave rr_ptr unchanged on any cycle without a grant.
REQ-022 SHALL clear out_valid next cycle when out_valid && out_ready && no grant.
REQ-023 SHALL hold out_data and out_warp_id stable while out_valid && !out_ready.
REQ-024 SHALL sustain one word per cycle when out_ready is held at 1 and at least one warp is eligible.
REQ-025 SHALL, on flush, clear out_valid next cycle, grant nothing that cycle, and leave rr_ptr unchanged; flush overrides out_ready.
REQ-026 SHALL have a latency of exactly 1 cycle from in_ready[k]=1 to out_valid=1 with that word.
REQ-027 SHALL ignore warp_stall for a word already registered in the output stage.

Reset
REQ-028 SHALL, on rst_n low, asynchronously force out_valid=0, out_data=0, out_warp_id=0, rr_ptr=0, dispatch_count=0.
REQ-029 SHALL drive in_ready=0 while rst_n is low.
REQ-030 SHALL discard any word held in the output stage when reset is asserted mid-operation.

Configuration
REQ-031 SHALL, with GELATO_DISPATCH_STATS_EN defined, increment dispatch_count on every cycle with out_valid && out_ready && !flush, wrapping at 2^32-1 -> 0.
REQ-032 SHALL, without GELATO_DISPATCH_STATS_EN, tie dispatch_count to 0 and instantiate no counter logic.

Verification
REQ-033 SHALL cover: reset, then in_valid=4'b1111, warp_stall=0, out_ready=1 -> out_warp_id 0,1,2,3,0 on consecutive cycles, out_valid held 1 from cycle 1.
REQ-034 SHALL cover: in_valid=4'b1010, rr_ptr=0 -> grants warp 1, then warp 3, then warp 1 (wrap).
REQ-035 SHALL cover: out_valid=1 with out_data=0xDEADBEEF, out_ready=0 for 3 cycles -> in_ready=0, out_data/out_warp_id unchanged; out_ready=1 -> next word loads the following cycle.
REQ-036 SHALL cover: in_valid=4'b0100, warp_stall=4'b0100 -> no grant, out_valid falls to 0; warp_stall drops -> warp 2 granted.
REQ-037 SHALL cover: flush=1 with out_valid=1, out_ready=1, in_valid=4'b1111 -> in_ready=0, out_valid=0 next cycle, rr_ptr unchanged.
REQ-038 SHALL cover: with GELATO_DISPATCH_STATS_EN defined, 10 accepted words -> dispatch_count=10; without it -> dispatch_count=0.
